axi_wr_burst_master: RTL

// - Parametrised DMA write-channel master: turns a burst command plus a beat stream into AXI AW/W traffic.
// - Retires B responses and tracks up to MAX_OUTST outstanding bursts.
// - Sits between the DMA descriptor engine and the AXI interconnect.
// - Replaces fixed-width, per-channel hand-driven AW/W/B signalling.

---
 rtl/axi_pkg.sv | 35 +++
 rtl/axi_wr_skid.sv | 45 ++++
 rtl/axi_wr_burst_master.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI write-master types, constants and helpers
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } wr_state_e;

  localparam logic [3:0] CACHE_BUF_MOD = 4'b0011;

  // AxSIZE encoding: log2 of the bytes per beat
  function automatic logic [2:0] size_f(input int data_w);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((8 << i) == data_w) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/axi_wr_skid.sv
// rtl/axi_wr_skid.sv - 2-entry valid/ready skid buffer, one cycle in->out latency
module axi_wr_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         out_free;

  // in_ready depends only on a register, so no combinational path from out_ready
  assign in_ready = !skid_valid;
  assign out_free = out_ready || !out_valid;

  // Output slot refills from the skid entry first so beat order is preserved
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/axi_wr_burst_master.sv
// rtl/axi_wr_burst_master.sv - DMA AXI write burst master (optional AXI_WR_STATS_EN counters)
module axi_wr_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int ID_W      = 8,
  parameter int LEN_W     = 8,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [ID_W-1:0]     cmd_id,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_strb,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [LEN_W-1:0]    aw_len,
  output logic [ID_W-1:0]     aw_id,
  output logic [1:0]          aw_burst,
  output logic [2:0]          aw_size,
  output logic                aw_lock,
  output logic [2:0]          aw_prot,
  output logic [3:0]          aw_cache,
  output logic [3:0]          aw_qos,
  output logic                w_valid,
  input  logic                w_ready,
  output logic                w_first,
  output logic                w_last,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic [ID_W-1:0]     w_id,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [1:0]          b_resp,
  input  logic [ID_W-1:0]     b_id,
  output logic                done_valid,
  output logic [ID_W-1:0]     done_id,
  output logic                done_err,
  output logic                busy
`ifdef AXI_WR_STATS_EN
  ,
  output logic [31:0]         stat_bursts,
  output logic [31:0]         stat_beats,
  output logic [15:0]         stat_errs
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OW     = $clog2(MAX_OUTST + 1);
  localparam int SK_W   = DATA_W + STRB_W + 2;
  localparam logic [OW-1:0] MAX_Q = OW'(MAX_OUTST);

  wr_state_e         state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [ID_W-1:0]   id_q;
  logic [OW-1:0]     outst;
  logic [LEN_W:0]    beat_cnt;
  logic              run;
  logic              data_ok;
  logic              beats_left;
  logic              cmd_hs, aw_hs, w_hs, b_hs, in_hs;
  logic              sk_in_valid, sk_in_ready, sk_out_valid;
  logic [SK_W-1:0]   sk_in_data, sk_out_data;

  assign cmd_hs     = cmd_valid && cmd_ready;
  assign aw_hs      = aw_valid && aw_ready;
  assign w_hs       = w_valid && w_ready;
  assign b_hs       = b_valid && b_ready;
  assign in_hs      = in_valid && in_ready;
  assign beats_left = (beat_cnt <= {1'b0, len_q});

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state: one burst at a time, W only after its own AW handshake
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (cmd_hs) state_nx = ST_ADDR;
      ST_ADDR: if (aw_hs) state_nx = ST_DATA;
      ST_DATA: if (w_hs && w_last) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs; run keeps cmd_ready low while reset is being released
  always_comb begin
    cmd_ready = 1'b0;
    aw_valid  = 1'b0;
    data_ok   = 1'b0;
    case (state)
      ST_IDLE: cmd_ready = run && (outst < MAX_Q);
      ST_ADDR: aw_valid  = 1'b1;
      ST_DATA: data_ok   = beats_left;
      default: ;
    endcase
  end

  // Command latch, beat counter, outstanding count and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run        <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      id_q       <= '0;
      beat_cnt   <= '0;
      outst      <= '0;
      done_valid <= 1'b0;
      done_id    <= '0;
      done_err   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (cmd_hs) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        id_q   <= cmd_id;
      end
      if (aw_hs)      beat_cnt <= '0;
      else if (in_hs) beat_cnt <= beat_cnt + 1'b1;
      if (aw_hs && !b_hs)      outst <= outst + 1'b1;
      else if (b_hs && !aw_hs) outst <= outst - 1'b1;
      done_valid <= b_hs;
      if (b_hs) begin
        done_id  <= b_id;
        done_err <= (b_resp != RESP_OKAY);
      end
    end
  end

  assign in_ready    = data_ok && sk_in_ready;
  assign sk_in_valid = in_valid && data_ok;
  assign sk_in_data  = {(beat_cnt == '0), (beat_cnt == {1'b0, len_q}), in_strb, in_data};

  axi_wr_skid #(.W(SK_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (sk_in_valid),
    .in_ready  (sk_in_ready),
    .in_data   (sk_in_data),
    .out_valid (sk_out_valid),
    .out_ready (w_ready),
    .out_data  (sk_out_data)
  );

  assign w_valid = sk_out_valid;
  assign {w_first, w_last, w_strb, w_data} = sk_out_data;
  assign w_id    = id_q;

  assign aw_addr  = addr_q;
  assign aw_len   = len_q;
  assign aw_id    = id_q;
  assign aw_burst = BURST_INCR;
  assign aw_size  = size_f(DATA_W);
  assign aw_lock  = 1'b0;
  assign aw_prot  = 3'b000;
  assign aw_cache = CACHE_BUF_MOD;
  assign aw_qos   = 4'b0000;

  assign b_ready = (outst != '0);
  assign busy    = (state != ST_IDLE) || (outst != '0);

`ifdef AXI_WR_STATS_EN
  // Saturating traffic counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_bursts <= '0;
      stat_beats  <= '0;
      stat_errs   <= '0;
    end else begin
      if (aw_hs && (stat_bursts != '1))             stat_bursts <= stat_bursts + 32'd1;
      if (w_hs && (stat_beats != '1))               stat_beats  <= stat_beats + 32'd1;
      if (done_valid && done_err && (stat_errs != '1)) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule
